// File: rtl/fft_frame_loader_if.sv
// Sample stream bundle for fft_frame_loader: upstream write side and FFT-core output side.
// The flush request ifls exists only when FFT_LOADER_FLUSH_EN is defined.
interface fft_frame_loader_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  ivalid;
  logic                  iready;
  logic [DATA_WIDTH-1:0] iReal;
  logic [DATA_WIDTH-1:0] iImag;
  logic                  oen;
  logic                  olast;
  logic [DATA_WIDTH-1:0] oReal;
  logic [DATA_WIDTH-1:0] oImag;
`ifdef FFT_LOADER_FLUSH_EN
  logic                  ifls;

  modport master (
    output ivalid, iReal, iImag, ifls,
    input  iready, oen, olast, oReal, oImag
  );
  modport slave (
    input  ivalid, iReal, iImag, ifls,
    output iready, oen, olast, oReal, oImag
  );
`else
  modport master (
    output ivalid, iReal, iImag,
    input  iready, oen, olast, oReal, oImag
  );
  modport slave (
    input  ivalid, iReal, iImag,
    output iready, oen, olast, oReal, oImag
  );
`endif
endinterface

// File: rtl/fft_frame_loader.sv
// Ping-pong frame buffer feeding an FFT core with gap-free N-sample bursts.
// Define FFT_LOADER_FLUSH_EN to add ifls: zero-pad a partial frame and emit it.
module fft_frame_loader #(
  parameter int TOTAL_STEP = 6,
  parameter int DATA_WIDTH = 16
) (
  input  logic              iclk,
  input  logic              rstn,
  fft_frame_loader_if.slave bus
);
  localparam int N  = 1 << TOTAL_STEP;
  localparam int AW = TOTAL_STEP;
  localparam int SW = 2 * DATA_WIDTH;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  typedef enum logic {IDLE, BURST} state_e;

  state_e          state_q, state_d;
  logic [1:0]      full_q, full_d;
  logic            wbank_q, wbank_d;
  logic            rbank_q, rbank_d;
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            zf_q, zf_d;
  logic            alive_q;
  logic [1:0]      vld_pipe_q, vld_pipe_d;
  logic            last_q, last_d;
  logic [SW-1:0]   rd_raw_q, rd_raw_d;

  logic            rdy;
  logic            clr;
  logic            wr_fire;
  logic            wr_en;
  logic            frame_done;
  logic            fls_start;
  logic            issue;
  logic [AW-1:0]   wptr_n;
  logic [SW-1:0]   wr_data;

  logic [SW-1:0]   mem [2][N];

  // ---------------- write side ----------------
  always_comb begin
    clr = (state_q == BURST) && (raddr_q == LAST);
    // A bank emptied by the burst ending this cycle is already writable.
    rdy = alive_q && !zf_q &&
          !(full_q[wbank_q] && !(clr && (rbank_q == wbank_q)));
    wr_fire    = bus.ivalid && rdy;
    wr_en      = wr_fire || zf_q;
    wr_data    = zf_q ? '0 : {bus.iReal, bus.iImag};
    wptr_n     = wr_en ? wptr_q + 1'b1 : wptr_q;
    frame_done = wr_en && (wptr_q == LAST);
`ifdef FFT_LOADER_FLUSH_EN
    // A write accepted alongside ifls is counted before deciding on the fill.
    fls_start  = bus.ifls && !zf_q && (wptr_n != '0);
`else
    fls_start  = 1'b0;
`endif
    zf_d    = zf_q ? !frame_done : fls_start;
    wptr_d  = wptr_n;
    wbank_d = wbank_q ^ frame_done;
    full_d  = full_q;
    if (clr)        full_d[rbank_q] = 1'b0;
    if (frame_done) full_d[wbank_q] = 1'b1;
  end

  // ---------------- read FSM ----------------
  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    rbank_d = rbank_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          state_d = BURST;
          raddr_d = '0;
          issue   = 1'b1;
        end
      end
      BURST: begin
        if (clr) begin
          state_d = IDLE;
          rbank_d = ~rbank_q;
        end else begin
          raddr_d = raddr_q + 1'b1;
          issue   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // vld_pipe[0]: address valid on the RAM port, vld_pipe[1]: data valid at the output.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], issue};
    last_d     = vld_pipe_q[0] && (raddr_q == LAST);
    rd_raw_d   = mem[rbank_q][raddr_q];
  end

  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      full_q     <= '0;
      wbank_q    <= 1'b0;
      rbank_q    <= 1'b0;
      wptr_q     <= '0;
      raddr_q    <= '0;
      zf_q       <= 1'b0;
      alive_q    <= 1'b0;
      vld_pipe_q <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      rbank_q    <= rbank_d;
      wptr_q     <= wptr_d;
      raddr_q    <= raddr_d;
      zf_q       <= zf_d;
      alive_q    <= 1'b1;
      vld_pipe_q <= vld_pipe_d;
      last_q     <= last_d;
    end
  end

  // Bank storage and its read register carry no reset; the output is masked by oen.
  always_ff @(posedge iclk) begin
    if (wr_en) mem[wbank_q][wptr_q] <= wr_data;
    rd_raw_q <= rd_raw_d;
  end

  assign bus.iready = rdy;
  assign bus.oen    = vld_pipe_q[1];
  assign bus.olast  = last_q;
  assign bus.oReal  = vld_pipe_q[1] ? rd_raw_q[SW-1:DATA_WIDTH] : '0;
  assign bus.oImag  = vld_pipe_q[1] ? rd_raw_q[DATA_WIDTH-1:0]  : '0;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Scoreboarded bench for fft_frame_loader: frame-level reference model feeds an
// expected queue that an independent output monitor drains.
module tb_fft_frame_loader;
  localparam int TS = 6;
  localparam int DW = 16;
  localparam int N  = 1 << TS;

  logic iclk = 1'b0;
  logic rstn = 1'b0;
  always #5 iclk = ~iclk;

  fft_frame_loader_if #(.DATA_WIDTH(DW)) bus();
  fft_frame_loader #(.TOTAL_STEP(TS), .DATA_WIDTH(DW)) dut (
    .iclk(iclk), .rstn(rstn), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  logic [2*DW:0]   exp_q[$];
  logic [2*DW-1:0] cur[$];
  int run_len   = 0;
  int first_oen = -1;
  int fall_cyc  = -1;
  int last_gap  = -1;
  int last_wr   = 0;
  int n_stall   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Reference model: whole frames become visible only once N samples are held.
  task automatic model_accept(input logic [DW-1:0] r, input logic [DW-1:0] im);
    cur.push_back({r, im});
    if (cur.size() == N) begin
      for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), cur[i]});
      cur.delete();
    end
  endtask

  // Output monitor
  always @(negedge iclk) begin
    logic [2*DW:0] e;
    if (!rstn) begin
      run_len  = 0;
      fall_cyc = -1;
    end else if (bus.oen) begin
      if (run_len == 0) begin
        first_oen = cyc;
        if (fall_cyc >= 0) last_gap = cyc - fall_cyc;
      end
      run_len++;
      if (exp_q.size() == 0) fail("unexpected_output");
      else begin
        e = exp_q.pop_front();
        chk("out_data", {bus.oReal, bus.oImag}, e[2*DW-1:0]);
        chk("out_last", bus.olast, e[2*DW]);
      end
    end else begin
      if (run_len != 0) begin
        chk("burst_len", run_len, N);
        run_len  = 0;
        fall_cyc = cyc;
      end
      chk("idle_outputs_zero", {bus.olast, bus.oReal, bus.oImag}, 0);
    end
  end

  task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] im, input int gap_pct);
    logic acc;
    int   b;
    while ($urandom_range(99) < gap_pct) begin
      bus.ivalid = 1'b0;
      @(posedge iclk); #1;
    end
    bus.ivalid = 1'b1;
    bus.iReal  = r;
    bus.iImag  = im;
    b = 0;
    do begin
      @(negedge iclk);
      acc = bus.iready;
      if (acc) model_accept(r, im);
      else n_stall++;
      @(posedge iclk); #1;
      b++;
    end while (!acc && b < 1000);
    if (!acc) fail("send_timeout");
    last_wr    = cyc;
    bus.ivalid = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.ivalid = 1'b0;
    #1;
    chk("rst_oen",    bus.oen,    0);
    chk("rst_olast",  bus.olast,  0);
    chk("rst_data",   {bus.oReal, bus.oImag}, 0);
    chk("rst_iready", bus.iready, 0);
    exp_q.delete();
    cur.delete();
    repeat (3) @(posedge iclk);
    @(negedge iclk);
    rstn = 1'b1;
    @(posedge iclk); #1;
    chk("iready_after_reset", bus.iready, 1);
  endtask

  task automatic drain();
    int b = 0;
    while ((exp_q.size() != 0 || bus.oen) && b < 1000) begin
      @(negedge iclk);
      b++;
    end
    if (b >= 1000) fail("drain_timeout");
    repeat (2) @(negedge iclk);
    @(posedge iclk); #1;
  endtask

`ifdef FFT_LOADER_FLUSH_EN
  task automatic flush();
    bus.ivalid = 1'b0;
    bus.ifls   = 1'b1;
    if (cur.size() > 0) while (cur.size() != 0) model_accept('0, '0);
    @(posedge iclk); #1;
    bus.ifls = 1'b0;
  endtask
`endif

  initial begin
    int b;
    bus.ivalid = 1'b0;
    bus.iReal  = '0;
    bus.iImag  = '0;
`ifdef FFT_LOADER_FLUSH_EN
    bus.ifls   = 1'b0;
`endif
    do_reset();

    // V-1: ramp frame, latency from last write to first oen
    for (int i = 0; i < N; i++) send(DW'(i), DW'(-i), 0);
    drain();
    chk("v1_latency", first_oen - last_wr, 2);

    // V-2: two back-to-back frames, no stall, one idle cycle between bursts
    last_gap = -1;
    n_stall  = 0;
    for (int i = 0; i < 2 * N; i++) send(DW'($urandom), DW'($urandom), 0);
    chk("v2_no_stall", n_stall, 0);
    drain();
    chk("v2_burst_gap", last_gap, 1);

    // V-3: three frames offered continuously
    for (int i = 0; i < 3 * N; i++) send(DW'(i * 7 + 3), DW'($urandom), 0);
    drain();

    // V-4: ramp frame with ~50% ivalid gaps
    for (int i = 0; i < N; i++) send(DW'(i), DW'(-i), 50);
    drain();

    // V-5: reset in the middle of a burst, then a fresh frame
    for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), 0);
    b = 0;
    while (run_len < 20 && b < 500) begin
      @(negedge iclk);
      b++;
    end
    if (b >= 500) fail("v5_burst_wait_timeout");
    do_reset();
    for (int i = 0; i < N; i++) send(DW'(i * 3), DW'(100 - i), 0);
    drain();

    // Random traffic
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N; i++) send(DW'($urandom), DW'($urandom), 30);
`ifdef FFT_LOADER_FLUSH_EN
      for (int i = 0; i < int'($urandom_range(N - 1, 1)); i++)
        send(DW'($urandom), DW'($urandom), 20);
      flush();
`endif
    end
    drain();

`ifdef FFT_LOADER_FLUSH_EN
    // V-6: partial frame of 10 then flush
    do_reset();
    for (int i = 0; i < 10; i++) send(DW'(i + 1), DW'(-(i + 1)), 0);
    flush();
    b = 0;
    forever begin
      @(negedge iclk);
      if (bus.iready || b >= 200) break;
      b++;
    end
    chk("v6_fill_cycles", b, N - 10);
    flush();
    drain();
`endif

    chk("model_partial_empty", cur.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
